// File: rtl/time_entry.sv
// Time/alarm digit entry: button-driven editor for a 24-hour HH:MM value.
// Each button is edge-detected, digits are edited with BCD wrap rules, and a
// one-cycle load strobe is issued to either the time or the alarm target.
module time_entry #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnSet,
    input  logic       btnInc,
    input  logic       btnNext,
    input  logic       selAlarm,
    output logic [1:0] hourIn1,
    output logic [3:0] hourIn0,
    output logic [3:0] minIn1,
    output logic [3:0] minIn0,
    output logic       ldTime,
    output logic       ldAlarm,
    output logic       editing,
    output logic [1:0] digitSel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_H1,
        S_H0,
        S_M1,
        S_M0,
        S_LOAD
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  w_btn;
    logic [2:0]  r_btn_q;
    logic [2:0]  r_btn_p;
    logic [2:0]  w_press;
    logic        r_primed;
    logic        w_any;
    logic        w_set;
    logic        w_inc;
    logic        w_nxt;

    logic        r_target;
    logic [15:0] r_cnt;
    logic        w_timeout;
    logic        w_edit_cur;
    logic        w_edit_next;

    logic [1:0]  r_h1;
    logic [3:0]  r_h0;
    logic [3:0]  r_m1;
    logic [3:0]  r_m0;
    logic [1:0]  w_h1;
    logic [3:0]  w_h0;
    logic [3:0]  w_m1;
    logic [3:0]  w_m0;

    logic        r_ldt;
    logic        r_lda;
    logic        r_edit;
    logic [1:0]  r_dsel;
    logic [1:0]  w_dsel;

    assign w_btn   = {btnNext, btnInc, btnSet};
    assign w_press = r_btn_q & ~r_btn_p;
    assign w_set   = w_press[0];
    assign w_inc   = w_press[1];
    assign w_nxt   = w_press[2];
    assign w_any   = |w_press;

    assign w_edit_cur  = (r_state == S_H1) || (r_state == S_H0) ||
                         (r_state == S_M1) || (r_state == S_M0);
    assign w_edit_next = (w_next == S_H1) || (w_next == S_H0) ||
                         (w_next == S_M1) || (w_next == S_M0);
    assign w_timeout   = w_edit_cur && !w_any && (r_cnt == 16'(TIMEOUT - 1));

    // Button history; the first edge after reset loads both stages from the
    // live input so a button held through reset release is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_q  <= '0;
            r_btn_p  <= '0;
            r_primed <= 1'b0;
        end else if (!r_primed) begin
            r_btn_q  <= w_btn;
            r_btn_p  <= w_btn;
            r_primed <= 1'b1;
        end else begin
            r_btn_q  <= w_btn;
            r_btn_p  <= r_btn_q;
        end
    end

    // Next digit values: increment the selected digit with its wrap limit.
    always_comb begin
        w_h1 = r_h1;
        w_h0 = r_h0;
        w_m1 = r_m1;
        w_m0 = r_m0;
        if (w_inc) begin
            case (r_state)
                S_H1: begin
                    w_h1 = (r_h1 == 2'd2) ? 2'd0 : r_h1 + 2'd1;
                    if (w_h1 == 2'd2 && r_h0 > 4'd3)
                        w_h0 = 4'd3;
                end
                S_H0: begin
                    if (r_h0 >= ((r_h1 == 2'd2) ? 4'd3 : 4'd9))
                        w_h0 = 4'd0;
                    else
                        w_h0 = r_h0 + 4'd1;
                end
                S_M1:    w_m1 = (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
                S_M0:    w_m0 = (r_m0 == 4'd9) ? 4'd0 : r_m0 + 4'd1;
                default: ;
            endcase
        end
    end

    // Next state and the digit selector that goes with it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_set) w_next = S_H1;
            S_H1:    if (w_nxt) w_next = S_H0;   else if (w_timeout) w_next = S_IDLE;
            S_H0:    if (w_nxt) w_next = S_M1;   else if (w_timeout) w_next = S_IDLE;
            S_M1:    if (w_nxt) w_next = S_M0;   else if (w_timeout) w_next = S_IDLE;
            S_M0:    if (w_nxt) w_next = S_LOAD; else if (w_timeout) w_next = S_IDLE;
            S_LOAD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        case (w_next)
            S_H0:    w_dsel = 2'd1;
            S_M1:    w_dsel = 2'd2;
            S_M0:    w_dsel = 2'd3;
            default: w_dsel = 2'd0;
        endcase
    end

    // Session FSM with registered digits, strobes, and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_target <= 1'b0;
            r_cnt    <= '0;
            r_h1     <= '0;
            r_h0     <= '0;
            r_m1     <= '0;
            r_m0     <= '0;
            r_ldt    <= 1'b0;
            r_lda    <= 1'b0;
            r_edit   <= 1'b0;
            r_dsel   <= '0;
        end else begin
            r_state <= w_next;
            r_h1    <= w_h1;
            r_h0    <= w_h0;
            r_m1    <= w_m1;
            r_m0    <= w_m0;
            if (r_state == S_IDLE && w_next == S_H1)
                r_target <= selAlarm;
            if (!w_edit_cur || !w_edit_next || w_any)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;
            r_edit <= w_edit_next;
            r_dsel <= w_dsel;
            r_ldt  <= (w_next == S_LOAD) && !r_target;
            r_lda  <= (w_next == S_LOAD) &&  r_target;
        end
    end

    assign hourIn1  = r_h1;
    assign hourIn0  = r_h0;
    assign minIn1   = r_m1;
    assign minIn0   = r_m0;
    assign ldTime   = r_ldt;
    assign ldAlarm  = r_lda;
    assign editing  = r_edit;
    assign digitSel = r_dsel;

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed vector table, hand-written
// corner sequences, and randomized buttons against a behavioural model.
module tb_time_entry;

    localparam int unsigned TO = 8;
    localparam logic [2:0] B_SET = 3'b001;
    localparam logic [2:0] B_INC = 3'b010;
    localparam logic [2:0] B_NXT = 3'b100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btnSet = 1'b0;
    logic       btnInc = 1'b0;
    logic       btnNext = 1'b0;
    logic       selAlarm = 1'b0;
    logic [1:0] hourIn1;
    logic [3:0] hourIn0;
    logic [3:0] minIn1;
    logic [3:0] minIn0;
    logic       ldTime;
    logic       ldAlarm;
    logic       editing;
    logic [1:0] digitSel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    time_entry #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .btnSet   (btnSet),
        .btnInc   (btnInc),
        .btnNext  (btnNext),
        .selAlarm (selAlarm),
        .hourIn1  (hourIn1),
        .hourIn0  (hourIn0),
        .minIn1   (minIn1),
        .minIn0   (minIn0),
        .ldTime   (ldTime),
        .ldAlarm  (ldAlarm),
        .editing  (editing),
        .digitSel (digitSel)
    );

    // Output vector layout: {h1, h0, m1, m0, editing, digitSel, ldTime, ldAlarm}
    logic [18:0] w_act;
    assign w_act = {hourIn1, hourIn0, minIn1, minIn0, editing, digitSel, ldTime, ldAlarm};

    function automatic logic [18:0] pk(int h1, int h0, int m1, int m0,
                                       int ed, int ds, int lt, int la);
        return {2'(h1), 4'(h0), 4'(m1), 4'(m0), 1'(ed), 2'(ds), 1'(lt), 1'(la)};
    endfunction

    task automatic check(string name, logic [18:0] exp);
        n_tests++;
        if (w_act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, w_act, exp);
        end
    endtask

    task automatic drive(logic [2:0] b);
        {btnNext, btnInc, btnSet} = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(logic [2:0] b, logic sel);
        selAlarm = sel;
        drive(b);
        step();
        drive(3'b000);
        step();
    endtask

    typedef struct {
        logic [2:0]  b;
        logic        sel;
        int          reps;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(logic [2:0] b, logic sel, int reps, logic [18:0] exp);
        vec_t v;
        v.b = b; v.sel = sel; v.reps = reps; v.exp = exp;
        return v;
    endfunction

    // Behavioural reference: mode 0 idle, 1..4 editing digit (mode-1), 5 load.
    int       m_mode;
    int       m_d[4];
    bit       m_tgt;
    bit [2:0] m_q;
    bit [2:0] m_p;
    bit       m_prim;
    int       m_cnt;
    bit       m_lt;
    bit       m_la;

    task automatic m_reset();
        m_mode = 0; m_tgt = 0; m_q = 0; m_p = 0; m_prim = 0; m_cnt = 0;
        m_lt = 0; m_la = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    task automatic m_bump(int k);
        int lim;
        case (k)
            0: begin
                m_d[0] = (m_d[0] + 1) % 3;
                if (m_d[0] == 2 && m_d[1] > 3) m_d[1] = 3;
            end
            1: begin
                lim = (m_d[0] == 2) ? 3 : 9;
                m_d[1] = (m_d[1] >= lim) ? 0 : m_d[1] + 1;
            end
            2: m_d[2] = (m_d[2] + 1) % 6;
            default: m_d[3] = (m_d[3] + 1) % 10;
        endcase
    endtask

    task automatic m_step(bit [2:0] b, bit sel);
        bit [2:0] pr;
        pr = m_q & ~m_p;
        m_lt = 0; m_la = 0;
        if (m_mode == 0) begin
            if (pr[0]) begin m_mode = 1; m_tgt = sel; m_cnt = 0; end
        end else if (m_mode == 5) begin
            m_mode = 0;
        end else begin
            if (pr[1]) m_bump(m_mode - 1);
            if (pr[2]) begin
                m_mode++;
                m_cnt = 0;
                if (m_mode == 5) begin
                    if (m_tgt) m_la = 1; else m_lt = 1;
                end
            end else if (pr != 0) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt >= int'(TO)) begin m_mode = 0; m_cnt = 0; end
            end
        end
        if (!m_prim) begin m_q = b; m_p = b; m_prim = 1; end
        else begin m_p = m_q; m_q = b; end
    endtask

    function automatic logic [18:0] m_exp();
        int ed;
        ed = (m_mode >= 1 && m_mode <= 4) ? 1 : 0;
        return pk(m_d[0], m_d[1], m_d[2], m_d[3], ed, ed ? m_mode - 1 : 0, m_lt, m_la);
    endfunction

    initial begin
        int idle_left;
        int r;

        // Reset state
        step();
        check("reset_held", pk(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        step();
        check("after_reset", pk(0, 0, 0, 0, 0, 0, 0, 0));

        // Directed table: full time entry, hour clamp, wrap limits
        tbl.push_back(mkv(B_SET, 0, 1, pk(0, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(1, 0, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(1, 0, 0, 0, 1, 1, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 2, pk(1, 2, 0, 0, 1, 1, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(1, 2, 0, 0, 1, 2, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(1, 2, 1, 0, 1, 2, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(1, 2, 1, 0, 1, 3, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 2, pk(1, 2, 1, 2, 1, 3, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(1, 2, 1, 2, 0, 0, 1, 0)));
        tbl.push_back(mkv(B_SET, 0, 1, pk(1, 2, 1, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(1, 2, 1, 2, 1, 1, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 7, pk(1, 9, 1, 2, 1, 1, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 3, pk(1, 9, 1, 2, 0, 0, 1, 0)));
        tbl.push_back(mkv(B_SET, 0, 1, pk(1, 9, 1, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(2, 3, 1, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(0, 3, 1, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 2, pk(2, 3, 1, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(2, 3, 1, 2, 1, 1, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(2, 0, 1, 2, 1, 1, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(2, 0, 1, 2, 1, 2, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 4, pk(2, 0, 5, 2, 1, 2, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(2, 0, 0, 2, 1, 2, 0, 0)));
        tbl.push_back(mkv(B_NXT, 0, 1, pk(2, 0, 0, 2, 1, 3, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 7, pk(2, 0, 0, 9, 1, 3, 0, 0)));
        tbl.push_back(mkv(B_INC, 0, 1, pk(2, 0, 0, 0, 1, 3, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].reps; k++) press(tbl[i].b, tbl[i].sel);
            check($sformatf("vec[%0d]", i), tbl[i].exp);
        end

        // Commit time, then one-cycle strobe ends
        press(B_NXT, 0);
        check("load_time", pk(2, 0, 0, 0, 0, 0, 1, 0));
        step();
        check("load_time_end", pk(2, 0, 0, 0, 0, 0, 0, 0));

        // Alarm session ending with Inc+Next in the same cycle
        press(B_SET, 1);
        check("alarm_h1", pk(2, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++) press(B_NXT, 1);
        check("alarm_m0", pk(2, 0, 0, 0, 1, 3, 0, 0));
        press(B_INC | B_NXT, 1);
        check("alarm_inc_next", pk(2, 0, 0, 1, 0, 0, 0, 1));
        step();
        check("alarm_strobe_end", pk(2, 0, 0, 1, 0, 0, 0, 0));
        step();
        check("idle_hold", pk(2, 0, 0, 1, 0, 0, 0, 0));

        // Inactivity timeout: still editing after TO-1 quiet cycles, idle after TO
        press(B_SET, 0);
        press(B_INC, 0);
        check("to_start", pk(0, 0, 0, 1, 1, 0, 0, 0));
        repeat (TO - 1) step();
        check("to_before", pk(0, 0, 0, 1, 1, 0, 0, 0));
        step();
        check("to_expired", pk(0, 0, 0, 1, 0, 0, 0, 0));

        // Asynchronous reset mid-session in M1
        press(B_SET, 0);
        press(B_NXT, 0);
        press(B_NXT, 0);
        check("pre_reset_m1", pk(0, 0, 0, 1, 1, 2, 0, 0));
        #2 reset = 1'b1;
        #1;
        check("async_reset", pk(0, 0, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b0;
        step();
        step();
        check("post_reset_idle", pk(0, 0, 0, 0, 0, 0, 0, 0));
        press(B_SET, 0);
        check("post_reset_set", pk(0, 0, 0, 0, 1, 0, 0, 0));

        // Set held through reset release is not a press until re-pressed
        drive(B_SET);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        check("held_set_ignored", pk(0, 0, 0, 0, 0, 0, 0, 0));
        drive(3'b000);
        step();
        press(B_SET, 0);
        check("repress_set", pk(0, 0, 0, 0, 1, 0, 0, 0));

        // Randomized buttons against the reference model
        reset = 1'b1;
        drive(3'b000);
        step();
        m_reset();
        reset = 1'b0;
        idle_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (idle_left > 0) begin
                drive(3'b000);
                idle_left--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 3)       idle_left = int'($urandom_range(8, 12));
                else if (r < 40) drive(3'($urandom_range(0, 7)));
                else if (r < 75) drive(3'b000);
            end
            selAlarm = 1'($urandom_range(0, 1));
            @(posedge clk);
            m_step({btnNext, btnInc, btnSet}, selAlarm);
            #1;
            check($sformatf("rand[%0d]", i), m_exp());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Load strobes are mutually exclusive at all times
    always @(negedge clk) begin
        if (ldTime && ldAlarm) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_excl: got ldTime=%b ldAlarm=%b expected not both", ldTime, ldAlarm);
        end
    end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter TIMEOUT, default 1000, inactivity abort limit in clk cycles (range 2..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 btnSet  input  1  level, starts an edit session.
REQ-005 btnInc  input  1  level, increments selected digit.
REQ-006 btnNext  input  1  level, advances to next digit / commits.
REQ-007 selAlarm  input  1  0 = edit target is time, 1 = alarm; sampled at session start.
REQ-008 hourIn1  output  2  hour tens digit (BCD), feeds alarm.hourIn1.
REQ-009 hourIn0  output  4  hour units digit (BCD), feeds alarm.hourIn0.
REQ-010 minIn1  output  4  minute tens digit (BCD), feeds alarm.minIn1.
REQ-011 minIn0  output  4  minute units digit (BCD), feeds alarm.minIn0.
REQ-012 ldTime  output  1  one-cycle load strobe for the current time.
REQ-013 ldAlarm  output  1  one-cycle load strobe for the alarm time.
REQ-014 editing  output  1  high while a session is active (states H1..M0).
REQ-015 digitSel  output  2  selected digit: 0=hourIn1, 1=hourIn0, 2=minIn1, 3=minIn0.

Function
REQ-016 Each button SHALL be registered and acted on only at a 0->1 transition of the registered value; a held button counts as one press.
REQ-017 States SHALL be IDLE, H1, H0, M1, M0, LOAD.
REQ-018 IDLE + btnSet press -> H1; selAlarm latched as target; digit registers keep their current values.
REQ-019 btnNext press: H1->H0->M1->M0->LOAD; btnSet presses outside IDLE are ignored.
REQ-020 LOAD SHALL last exactly one cycle, assert ldTime (target 0) or ldAlarm (target 1) for that cycle only, then go to IDLE.
REQ-021 Digit values SHALL be stable during the LOAD cycle and held unchanged in IDLE.
REQ-022 btnInc press increments the selected digit with wrap: hourIn1 0..2, hourIn0 0..9 (0..3 when hourIn1=2), minIn1 0..5, minIn0 0..9.
REQ-023 When hourIn1 becomes 2 while hourIn0>3, hourIn0 SHALL be clamped to 3 in the same cycle.
REQ-024 btnInc and btnNext presses in the same cycle: the increment applies to the current digit, then the state advances.
REQ-025 An inactivity counter SHALL clear on every press and on entering H1; after TIMEOUT consecutive press-free cycles in H1..M0, the block returns to IDLE with no strobe, and edited digits keep their values.
REQ-026 editing=1 in H1..M0, else 0; digitSel=0/1/2/3 in H1/H0/M1/M0, 0 otherwise.
REQ-027 ldTime and ldAlarm SHALL never be asserted together.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, all digits 0, ldTime=ldAlarm=0, editing=0, digitSel=0, counter 0, and button history 0, independent of clk.
REQ-029 Reset asserted mid-session SHALL abort the session with no strobe.
REQ-030 A button held high through reset release SHALL NOT count as a press until it is released and pressed again.

Verification
REQ-031 Set(selAlarm=0); Inc; Next; Inc x2; Next; Inc; Next; Inc x2; Next -> a one-cycle ldTime with digits 1,2,1,2; ldAlarm stays 0.
REQ-032 Digits 1,9,x,x; in H1 Inc -> hourIn1=2, hourIn0=3; Inc -> hourIn1=0, hourIn0=3.
REQ-033 minIn0 at 9, Inc -> 0; minIn1 at 5, Inc -> 0; hourIn0 at 3 with hourIn1=2, Inc -> 0.
REQ-034 TIMEOUT=8: Set, then 8 idle cycles -> editing=0, state IDLE, no strobe.
REQ-035 Set(selAlarm=1), walk to M0, Inc+Next in the same cycle -> minIn0 incremented, then a one-cycle ldAlarm strobe; ldTime stays 0.
REQ-036 Reset pulse while in M1 -> all outputs 0 immediately; a later Set starts from H1 with digits 0.
